// File: rtl/fifo_sync_pkg.sv
// Shared types and helpers for the fifo_sync read-side packer.
package fifo_sync_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam int FIFO_DATA_W = 8;

    // Low-order mask with cnt bits set; saturates at 32 lanes.
    function automatic logic [31:0] keep_mask(input int unsigned cnt);
        logic [31:0] mask_v;
        if (cnt >= 32'd32) begin
            mask_v = 32'hFFFF_FFFF;
        end else begin
            mask_v = (32'd1 << cnt) - 32'd1;
        end
        return mask_v;
    endfunction

endpackage

// File: rtl/fifo_sync_rd_packer.sv
// Reads bytes from fifo_sync and packs them LSB-first into words on a
// valid/ready stream; partial words leave on flush or idle timeout.
module fifo_sync_rd_packer
    import fifo_sync_pkg::*;
#(
    parameter int DATA_W         = FIFO_DATA_W,
    parameter int BYTES_PER_WORD = 4,
    parameter int TIMEOUT        = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en_i,
    output logic                             read_o,
    input  logic                             data_rd_i,
    input  logic [DATA_W-1:0]                data_i,
    input  logic                             flush_i,
    output logic [DATA_W*BYTES_PER_WORD-1:0] word_o,
    output logic [BYTES_PER_WORD-1:0]        keep_o,
    output logic                             valid_o,
    input  logic                             ready_i
);

    localparam int WORD_W = DATA_W * BYTES_PER_WORD;
    localparam int CNT_W  = $clog2(BYTES_PER_WORD + 1);
    localparam int TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BYTES_PER_WORD);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    state_e                    state_r, state_nxt_s;
    logic [CNT_W-1:0]          cnt_r, cnt_nxt_s, cnt_inc_s;
    logic [TMO_W-1:0]          tmo_r;
    logic [WORD_W-1:0]         word_r, word_nxt_s;
    logic [BYTES_PER_WORD-1:0] keep_r, keep_nxt_s, mask_s;
    logic                      valid_r, valid_nxt_s;
    logic                      accept_s, tmo_exp_s;

    // Reset also silences the read request so the FIFO is not drained while held.
    assign read_o    = en_i && (state_r == FILL) && !rst;
    assign accept_s  = read_o && data_rd_i;
    assign cnt_inc_s = cnt_r + CNT_W'(accept_s);
    assign tmo_exp_s = (state_r == FILL) && (cnt_r != {CNT_W{1'b0}}) && (tmo_r == TMO_LAST);
    assign mask_s    = BYTES_PER_WORD'(keep_mask(32'(cnt_inc_s)));

    assign word_o  = word_r;
    assign keep_o  = keep_r;
    assign valid_o = valid_r;

    // Next-state and packing logic; a same-cycle byte lands before any flush decision.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        word_nxt_s  = word_r;
        keep_nxt_s  = keep_r;
        valid_nxt_s = valid_r;
        case (state_r)
            FILL: begin
                if (accept_s) begin
                    for (int lane = 0; lane < BYTES_PER_WORD; lane++) begin
                        if (cnt_r == CNT_W'(lane)) begin
                            word_nxt_s[lane*DATA_W +: DATA_W] = data_i;
                        end else begin
                            word_nxt_s[lane*DATA_W +: DATA_W] = word_r[lane*DATA_W +: DATA_W];
                        end
                    end
                    cnt_nxt_s = cnt_inc_s;
                end else begin
                    cnt_nxt_s = cnt_r;
                end
                if (cnt_inc_s == CNT_FULL) begin
                    state_nxt_s = HOLD;
                    keep_nxt_s  = {BYTES_PER_WORD{1'b1}};
                    valid_nxt_s = 1'b1;
                end else if ((flush_i || tmo_exp_s) && (cnt_inc_s != {CNT_W{1'b0}})) begin
                    state_nxt_s = HOLD;
                    keep_nxt_s  = mask_s;
                    valid_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = FILL;
                end
            end
            HOLD: begin
                if (ready_i) begin
                    state_nxt_s = FILL;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    word_nxt_s  = {WORD_W{1'b0}};
                    keep_nxt_s  = {BYTES_PER_WORD{1'b0}};
                    valid_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = FILL;
                cnt_nxt_s   = {CNT_W{1'b0}};
                word_nxt_s  = {WORD_W{1'b0}};
                keep_nxt_s  = {BYTES_PER_WORD{1'b0}};
                valid_nxt_s = 1'b0;
            end
        endcase
    end

    // State, lane count and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= FILL;
            cnt_r   <= {CNT_W{1'b0}};
            word_r  <= {WORD_W{1'b0}};
            keep_r  <= {BYTES_PER_WORD{1'b0}};
            valid_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            word_r  <= word_nxt_s;
            keep_r  <= keep_nxt_s;
            valid_r <= valid_nxt_s;
        end
    end

    // Idle timer: runs only while a partial word waits in FILL with no new byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_r <= {TMO_W{1'b0}};
        end else if ((state_r != FILL) || (cnt_r == {CNT_W{1'b0}}) || accept_s || tmo_exp_s) begin
            tmo_r <= {TMO_W{1'b0}};
        end else begin
            tmo_r <= tmo_r + TMO_W'(1);
        end
    end

endmodule
